// File: rtl/lsu_data_memory_if.sv
// Request/response bus between the execute/memory stage and the data memory.
// The requester drives the master side; the memory implements the slave side.
interface lsu_data_memory_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned,
        output req_ready, rsp_valid, rsp_rdata, rsp_error, busy
    );
endinterface

// File: rtl/lsu_data_memory.sv
// Load/store data memory: one request at a time, byte/half/word accesses with
// RV32I extension, LATENCY wait states, error reporting for misaligned,
// illegal-size and out-of-range requests. Storage is four byte-lane RAMs.
module lsu_data_memory #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    lsu_data_memory_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        enter_resp;
    logic        accept;

    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        unsigned_q;

    logic        op_write;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [1:0]  op_size;
    logic        op_error;
    logic [ADDR_WIDTH-1:0] op_index;
    logic [3:0]  op_be;
    logic [31:0] op_wlanes;
    logic        mem_we;

    logic [31:0] rd_word;
    logic        rsp_load_q;
    logic        rsp_error_q;
    logic [31:0] shifted;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    assign accept = bus.req_valid && (state_q == S_IDLE);

    // Next-state logic; enter_resp marks the edge on which the array is accessed
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d = 4'd0;
                    if (LATENCY == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'(LATENCY - 1)) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and wait-counter registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request on the accepting edge
    always_ff @(posedge clk) begin
        if (accept) begin
            write_q    <= bus.req_write;
            addr_q     <= bus.req_addr;
            wdata_q    <= bus.req_wdata;
            size_q     <= bus.req_size;
            unsigned_q <= bus.req_unsigned;
        end
    end

    // With zero wait states the access happens on the accepting edge itself,
    // so the live request is used while still in IDLE
    always_comb begin
        if (state_q == S_IDLE) begin
            op_write = bus.req_write;
            op_addr  = bus.req_addr;
            op_wdata = bus.req_wdata;
            op_size  = bus.req_size;
        end else begin
            op_write = write_q;
            op_addr  = addr_q;
            op_wdata = wdata_q;
            op_size  = size_q;
        end
    end

    // Error detection, lane enables and lane-replicated store data
    always_comb begin
        op_error = (op_size == 2'b11)
                || (op_size == 2'b01 && op_addr[0])
                || (op_size == 2'b10 && op_addr[1:0] != 2'b00)
                || ((op_addr >> (ADDR_WIDTH + 2)) != 32'd0);
        op_index = op_addr[ADDR_WIDTH+1:2];
        case (op_size)
            2'b00:   op_be = 4'b0001 << op_addr[1:0];
            2'b01:   op_be = op_addr[1] ? 4'b1100 : 4'b0011;
            2'b10:   op_be = 4'b1111;
            default: op_be = 4'b0000;
        endcase
        case (op_size)
            2'b00:   op_wlanes = {4{op_wdata[7:0]}};
            2'b01:   op_wlanes = {2{op_wdata[15:0]}};
            default: op_wlanes = op_wdata;
        endcase
    end

    // A reset on the access edge drops the pending store
    assign mem_we = enter_resp && reset_n && op_write && !op_error;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] ram_q [DEPTH];
            logic [7:0] rd_byte_q;

            // Byte-lane RAM with registered read
            always_ff @(posedge clk) begin
                if (mem_we && op_be[gi]) begin
                    ram_q[op_index] <= op_wlanes[8*gi +: 8];
                end
                if (enter_resp) begin
                    rd_byte_q <= ram_q[op_index];
                end
            end

            assign rd_word[8*gi +: 8] = rd_byte_q;
        end
    endgenerate

    // Response qualifiers: load data only for error-free loads
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rsp_load_q  <= 1'b0;
            rsp_error_q <= 1'b0;
        end else if (enter_resp) begin
            rsp_load_q  <= !op_write && !op_error;
            rsp_error_q <= op_error;
        end else if (state_q == S_RESP) begin
            rsp_load_q  <= 1'b0;
            rsp_error_q <= 1'b0;
        end
    end

    // Lane extraction and sign/zero extension of the registered read word
    always_comb begin
        shifted  = rd_word >> {addr_q[1:0], 3'b000};
        half_sel = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (size_q)
            2'b00:   load_ext = unsigned_q ? {24'd0, shifted[7:0]}
                                           : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = unsigned_q ? {16'd0, half_sel}
                                           : {{16{half_sel[15]}}, half_sel};
            default: load_ext = rd_word;
        endcase
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q == S_WAIT) || (state_q == S_RESP);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_error = rsp_error_q;
    assign bus.rsp_rdata = rsp_load_q ? load_ext : 32'd0;
endmodule

// File: doc/lsu_data_memory.md
# lsu_data_memory

Parametrised data memory with a load/store front end for the RISC-V CPU. It accepts one request at a time over a valid/ready handshake and supports byte, halfword and word accesses with RV32I sign/zero extension. Each access has a configurable number of wait states, and misaligned or out-of-range requests are reported as errors. It sits between the execute/memory stage and the backing word array and replaces the fixed single-cycle word memory.

## Interface
- ADDR_WIDTH, 8: word-address bits; depth = 2^ADDR_WIDTH words (default 256 words, 1 KB)
- LATENCY, 1: wait states inserted per access, 0..15

- clk  input  1  clock, all logic on rising edge
- reset_n  input  1  synchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request (high only in IDLE)
- req_write  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  input  1  loads only: 1 = zero-extend (LBU/LHU), 0 = sign-extend
- rsp_valid  output  1  one-cycle response pulse
- rsp_rdata  output  32  load result, extended; 0 for stores and errors
- rsp_error  output  1  qualified by rsp_valid; misaligned, illegal size or out of range
- busy  output  1  high in WAIT or RESP

## Operation
- Reset behaviour:
  - Reset is synchronous: on a clk edge with reset_n=0, state goes to IDLE, the wait counter clears, and rsp_valid, rsp_rdata, rsp_error and busy go to 0.
  - req_ready is 1 from the first cycle after reset.
  - Memory array contents are NOT cleared by reset.
- State IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch write, addr, wdata, size and unsigned.
  - Go to WAIT if LATENCY>0, otherwise to RESP. Inputs are ignored outside the accepting edge.
- State WAIT:
  - The counter counts LATENCY cycles, then the state goes to RESP.
- State RESP:
  - rsp_valid=1 for exactly one cycle, then return to IDLE.
  - There is no response back-pressure; the requester must consume the pulse.
- Access execution (the array is updated and read on the edge entering RESP):
  - Error conditions:
    - size=11
    - size=01 with addr[0]=1
    - size=10 with addr[1:0]≠0
    - addr[31:ADDR_WIDTH+2] ≠ 0
  - On error: no array write, rsp_rdata=0, rsp_error=1.
  - Word index is addr[ADDR_WIDTH+1:2]; byte lane is addr[1:0].
  - Store byte: wdata[7:0] is written to lane addr[1:0]; the other lanes are unchanged.
  - Store half: wdata[15:0] is written to lanes {addr[1],0} and {addr[1],1}.
  - Store word: all four lanes are written.
  - Load: extract the addressed byte or half, then sign- or zero-extend it to 32 bits per req_unsigned. A word load returns the word unchanged.
  - req_unsigned is ignored for stores and word loads.
- Reset mid-operation: an accepted but unfinished request (in WAIT) is dropped. A pending store is not performed and no response is produced.

## Timing
- Accept edge T (req_valid&&req_ready sampled high).
- rsp_valid is high during cycle T+1+LATENCY: cycle T+1 for LATENCY=0, T+2 for LATENCY=1.
- req_ready falls in cycle T+1 and rises again in cycle T+2+LATENCY.
- Peak throughput is one request per LATENCY+2 cycles.
- A store is visible to any load accepted after its rsp_valid cycle.
- All outputs are registered; req_ready and busy are decoded directly from the state register.

## Test plan
- Reset, then LATENCY=1: store word 0xDEADBEEF to 0x10, then load word 0x10 → rsp_valid 2 cycles after each accept, rdata=0xDEADBEEF, error=0.
- Byte and halfword loads of word 0x10:
  - Store byte 0x80 to 0x13.
  - LB 0x13 → 0xFFFFFF80.
  - LBU 0x13 → 0x00000080.
  - LH 0x10 → 0xFFFFBEEF.
  - LHU 0x12 → 0x000080AD.
- Misalignment and range errors (array unchanged in every case):
  - Half store to 0x11 → error=1.
  - Word load at 0x12 → error=1, rdata=0.
  - size=11 → error=1.
  - Address 0x400 with ADDR_WIDTH=8 → error=1.
- Handshake: hold req_valid high continuously → exactly one accept per LATENCY+2 cycles; req_ready=0 while busy=1; no double accept.
- LATENCY=0 and LATENCY=15 builds: rsp_valid arrives at T+1 and T+16 respectively.
- Reset mid-operation:
  - Assert reset_n=0 during WAIT of a store to 0x20 → no rsp_valid, word 0x20 unchanged.
  - Separately, load word 0x10 after reset → still returns the previously stored value.
